// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: word-addressed data RAM for the MEM stage with fixed access latency and pipeline stall
module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic rd_req, load, req, fault, accept, access;
  logic [AW-1:0] idx;
  always_comb begin
    rd_req = ResultSrcM == 2'b01;
    load = rd_req & ~MemWriteM;
    req = MemWriteM | rd_req;
    fault = (ALUResultM[1:0] != 2'b00) | (ALUResultM >= 32'(4 * DEPTH_WORDS));
    idx = ALUResultM[AW+1:2];
    // reset overrides a request held on the inputs so the pipeline is never stalled during reset
    accept = ~reset & (state == IDLE) & req & ~fault;
    access = (accept & (LATENCY == 1)) | ((state == BUSY) & (cnt == 4'd0));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? (LATENCY == 1 ? DONE : BUSY) : IDLE) :
               state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
  always_comb begin
    StallM = accept | (state == BUSY);
    MemErrM = ~reset & (state == IDLE) & req & fault;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= 4'd0;
      ReadDataM <= 32'h0;
    end else begin
      if (accept) cnt <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
      else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (access && load) ReadDataM <= mem[idx];
      else if (MemErrM && load) ReadDataM <= 32'h0;
    end
  always_ff @(posedge clk)
    if (access && MemWriteM) mem[idx] <= WriteDataM;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb_mem_stage_dmem: directed bench with a transaction-level memory model for two latency configurations
module tb_mem_stage_dmem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        we [2];
  logic [1:0]  rs [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        stall [2];
  logic        err [2];
  logic [31:0] mem_m [2][64];
  logic        exp_stall [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];
  int checks = 0;
  int errors = 0;
  int stall_hi [2];

  mem_stage_dmem #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .MemWriteM(we[0]), .ResultSrcM(rs[0]), .ALUResultM(addr[0]),
    .WriteDataM(wd[0]), .ReadDataM(rd[0]), .StallM(stall[0]), .MemErrM(err[0]));
  mem_stage_dmem #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MemWriteM(we[1]), .ResultSrcM(rs[1]), .ALUResultM(addr[1]),
    .WriteDataM(wd[1]), .ReadDataM(rd[1]), .StallM(stall[1]), .MemErrM(err[1]));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk)
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("stall%0d", s), 32'(stall[s]), 32'(exp_stall[s]));
      chk($sformatf("err%0d", s), 32'(err[s]), 32'(exp_err[s]));
      chk($sformatf("rdata%0d", s), rd[s], exp_rd[s]);
      if (stall[s]) stall_hi[s]++;
    end

  // One complete request: holds the inputs for the whole access and predicts every cycle's outputs.
  task automatic access(int s, logic w, logic [1:0] r, logic [31:0] a, logic [31:0] d);
    int lat;
    logic flt, ld, req;
    lat = s == 1 ? 1 : 2;
    flt = (a[1:0] != 2'b00) || (a >= 32'd256);
    req = w || r == 2'b01;
    ld = r == 2'b01 && !w;
    we[s] = w; rs[s] = r; addr[s] = a; wd[s] = d;
    if (!req) begin
      @(posedge clk); #1;
    end else if (flt) begin
      exp_err[s] = 1'b1;
      @(posedge clk); #1;
      exp_err[s] = 1'b0;
      if (ld) exp_rd[s] = 32'h0;
    end else begin
      exp_stall[s] = 1'b1;
      repeat (lat) begin @(posedge clk); #1; end
      exp_stall[s] = 1'b0;
      if (w) mem_m[s][a[7:2]] = d;
      else if (ld) exp_rd[s] = mem_m[s][a[7:2]];
      @(posedge clk); #1;
    end
    we[s] = 1'b0; rs[s] = 2'b00; addr[s] = 32'h0; wd[s] = 32'h0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      we[s] = 1'b0; rs[s] = 2'b00; addr[s] = 32'h0; wd[s] = 32'h0;
      exp_stall[s] = 1'b0; exp_err[s] = 1'b0; exp_rd[s] = 32'h0; stall_hi[s] = 0;
      for (int i = 0; i < 64; i++) mem_m[s][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rdata", rd[0], 32'h0);
    chk("reset_stall", 32'(stall[0]), 32'h0);
    chk("reset_err", 32'(err[0]), 32'h0);
    // store then load through the 2-cycle RAM
    stall_hi[0] = 0;
    access(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    chk("t1_store_stall_cycles", 32'(stall_hi[0]), 32'd2);
    stall_hi[0] = 0;
    access(0, 1'b0, 2'b01, 32'h10, 32'h0);
    chk("t1_load_stall_cycles", 32'(stall_hi[0]), 32'd2);
    chk("t1_load_data", rd[0], 32'hDEADBEEF);
    // misaligned load faults and clears the load data
    stall_hi[0] = 0;
    access(0, 1'b0, 2'b01, 32'h13, 32'h0);
    chk("t2_rdata_cleared", rd[0], 32'h0);
    chk("t2_no_stall", 32'(stall_hi[0]), 32'd0);
    // out-of-range store must not alias onto word 0
    access(0, 1'b1, 2'b00, 32'h0, 32'h77);
    stall_hi[0] = 0;
    access(0, 1'b1, 2'b00, 32'h100, 32'h55);
    chk("t3_no_stall", 32'(stall_hi[0]), 32'd0);
    access(0, 1'b0, 2'b01, 32'h0, 32'h0);
    chk("t3_word0_intact", rd[0], 32'h77);
    // back-to-back loads
    access(0, 1'b1, 2'b00, 32'h4, 32'h11);
    access(0, 1'b1, 2'b00, 32'h8, 32'h22);
    stall_hi[0] = 0;
    access(0, 1'b0, 2'b01, 32'h4, 32'h0);
    chk("t4_first_load", rd[0], 32'h11);
    access(0, 1'b0, 2'b01, 32'h8, 32'h0);
    chk("t4_second_load", rd[0], 32'h22);
    chk("t4_stall_cycles", 32'(stall_hi[0]), 32'd4);
    // reset in the first BUSY cycle discards the pending store
    access(0, 1'b1, 2'b00, 32'h20, 32'h1234);
    we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hCAFE;
    exp_stall[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_stall[0] = 1'b0; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    #1;
    chk("t5_stall_on_reset", 32'(stall[0]), 32'h0);
    chk("t5_rdata_on_reset", rd[0], 32'h0);
    @(posedge clk); #1;
    we[0] = 1'b0; addr[0] = 32'h0; wd[0] = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    access(0, 1'b0, 2'b01, 32'h20, 32'h0);
    chk("t5_old_value", rd[0], 32'h1234);
    // single-cycle RAM: store and load request together acts as a store
    stall_hi[1] = 0;
    access(1, 1'b1, 2'b01, 32'h8, 32'hABCD);
    chk("t6_stall_cycles", 32'(stall_hi[1]), 32'd1);
    chk("t6_rdata_unchanged", rd[1], 32'h0);
    access(1, 1'b0, 2'b01, 32'h8, 32'h0);
    chk("t6_store_landed", rd[1], 32'hABCD);
    access(1, 1'b0, 2'b01, 32'hFC, 32'h0);
    chk("t6_last_word_zero_model", rd[1], 32'h0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
